// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative signed divider: FSM state
// encodings and default sizing.
package div_iter_pkg;

    localparam int DIV_WIDTH_DEF = 32;
    localparam int DIV_CNT_W_DEF = 6;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_FIXUP   = 2'd2;
    localparam logic [1:0] ST_SPECIAL = 2'd3;

endpackage

// File: rtl/div_step.sv
// One non-restoring division step: adds or subtracts the divisor magnitude
// from a WIDTH+1-bit partial remainder and derives the quotient bit.
module div_step
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF
) (
    input  logic [WIDTH:0]   part_rem,
    input  logic [WIDTH-1:0] dvsr,
    input  logic             add_sel,
    output logic [WIDTH:0]   next_rem,
    output logic             q_bit
);

    // A negative partial remainder is restored by adding, otherwise subtract.
    always_comb begin
        if (add_sel) begin
            next_rem = part_rem + {1'b0, dvsr};
        end else begin
            next_rem = part_rem - {1'b0, dvsr};
        end
        q_bit = ~next_rem[WIDTH];
    end

endmodule

// File: rtl/div_iter.sv
// Iterative signed divider: one quotient bit per clock by non-restoring
// division on operand magnitudes, followed by a sign fix-up cycle.
// Divide-by-zero and INT_MIN / -1 short-circuit through a single
// SPECIAL cycle and raise the exception flag.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF,
    parameter int CNT_W = DIV_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             exception,
    output logic             ready,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] NEG_ONE  = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;

    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             exception_q, exception_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic             div_by_zero;
    logic             overflow;
    logic [WIDTH:0]   step_part;
    logic             step_add;
    logic [WIDTH:0]   step_next;
    logic             step_qbit;
    logic [WIDTH-1:0] fixed_rem;
    logic [CNT_W-1:0] cnt_inc;

    // Operand magnitudes and the two exceptional operand combinations.
    always_comb begin
        dividend_mag = dividend[WIDTH-1] ? (~dividend + ONE) : dividend;
        divisor_mag  = divisor[WIDTH-1]  ? (~divisor + ONE)  : divisor;
        div_by_zero  = (divisor == '0);
        overflow     = (dividend == INT_MIN) && (divisor == NEG_ONE);
    end

    // Feed the shared step unit: shifted remainder while iterating,
    // unshifted remainder with a forced add for the final correction.
    always_comb begin
        if (state_q == ST_FIXUP) begin
            step_part = rem_q;
            step_add  = 1'b1;
        end else begin
            step_part = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
            step_add  = rem_q[WIDTH];
        end
        fixed_rem = rem_q[WIDTH] ? step_next[WIDTH-1:0] : rem_q[WIDTH-1:0];
        cnt_inc   = cnt_q + CNT_ONE;
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .part_rem (step_part),
        .dvsr     (dvsr_q),
        .add_sel  (step_add),
        .next_rem (step_next),
        .q_bit    (step_qbit)
    );

    // Next-state logic: a start always wins and recaptures the operands,
    // which silently abandons any operation still in flight.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        dvsr_d      = dvsr_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        exception_d = exception_q;
        ready_d     = 1'b0;
        busy_d      = busy_q;

        if (start) begin
            busy_d     = 1'b1;
            cnt_d      = '0;
            dvsr_d     = divisor_mag;
            neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d  = dividend[WIDTH-1];
            if (div_by_zero) begin
                state_d = ST_SPECIAL;
                quot_d  = '0;
                rem_d   = {1'b0, dividend};
            end else if (overflow) begin
                state_d = ST_SPECIAL;
                quot_d  = INT_MIN;
                rem_d   = '0;
            end else begin
                state_d = ST_RUN;
                quot_d  = dividend_mag;
                rem_d   = '0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    rem_d  = step_next;
                    quot_d = {quot_q[WIDTH-2:0], step_qbit};
                    cnt_d  = cnt_inc;
                    if (cnt_inc == CNT_LAST) begin
                        state_d = ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    quotient_d  = neg_quot_q ? (~quot_q + ONE) : quot_q;
                    remainder_d = neg_rem_q ? (~fixed_rem + ONE) : fixed_rem;
                    exception_d = 1'b0;
                    ready_d     = 1'b1;
                    busy_d      = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end
                ST_SPECIAL: begin
                    quotient_d  = quot_q;
                    remainder_d = rem_q[WIDTH-1:0];
                    exception_d = 1'b1;
                    ready_d     = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            dvsr_q      <= '0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            exception_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            dvsr_q      <= dvsr_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            exception_q <= exception_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign exception = exception_q;
    assign ready     = ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed and randomized bench for div_iter with a result scoreboard.
module tb_div_iter;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        exception;
    logic        ready;
    logic        busy;

    int   compared    = 0;
    int   mismatched  = 0;
    int   ready_count = 0;
    exp_t sbq[$];

    div_iter dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .exception (exception),
        .ready     (ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Count every ready cycle so stray or missing pulses can be detected.
    always @(negedge clk) begin
        if (ready === 1'b1) ready_count++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compareVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one start pulse captured on the next rising edge (E0).
    task automatic applyStimulus(input logic [31:0] dvd, input logic [31:0] dvs, input bit expect_result,
                                 input logic [31:0] q, input logic [31:0] r, input logic e);
        exp_t item;
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        if (expect_result) begin
            item.q = q;
            item.r = r;
            item.e = e;
            sbq.push_back(item);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for ready, then score the result against the queue.
    task automatic checkOutput(input string tag, input int latency);
        int   edges    = 0;
        bit   found    = 1'b0;
        bit   busy_gap = 1'b0;
        exp_t item;
        while (!found && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (ready === 1'b1) found = 1'b1;
            else if (busy !== 1'b1) busy_gap = 1'b1;
        end
        compared++;
        assert (found) else begin
            mismatched++;
            $error("[TB] FAIL %s_ready: observed no ready expected ready within 200 edges", tag);
        end
        if (found) begin
            compareVal({tag, "_sb_depth"}, 32'(sbq.size()), 32'd1);
            if (sbq.size() > 0) begin
                item = sbq.pop_front();
                compareVal({tag, "_quotient"}, quotient, item.q);
                compareVal({tag, "_remainder"}, remainder, item.r);
                compareVal({tag, "_exception"}, {31'b0, exception}, {31'b0, item.e});
            end
            compareVal({tag, "_latency"}, 32'(edges), 32'(latency));
            compareVal({tag, "_busy_gap"}, {31'b0, busy_gap}, 32'd0);
            compareVal({tag, "_busy_at_ready"}, {31'b0, busy}, 32'd0);
            @(posedge clk);
            #1;
            compareVal({tag, "_ready_pulse"}, {31'b0, ready}, 32'd0);
        end
    endtask

    initial begin
        int          base;
        int signed   a;
        int signed   b;
        logic [31:0] qm;
        logic [31:0] rm;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        compareVal("reset_quotient", quotient, 32'd0);
        compareVal("reset_remainder", remainder, 32'd0);
        compareVal("reset_exception", {31'b0, exception}, 32'd0);
        compareVal("reset_ready", {31'b0, ready}, 32'd0);
        compareVal("reset_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(32'd7, 32'd2, 1'b1, 32'd3, 32'd1, 1'b0);
        compareVal("busy_after_start", {31'b0, busy}, 32'd1);
        checkOutput("pos_7_2", 33);

        applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        checkOutput("neg_7_2", 33);

        applyStimulus(32'd5, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        checkOutput("pos5_neg3", 33);

        applyStimulus(32'hFFFF_FFFB, 32'hFFFF_FFFD, 1'b1, 32'd1, 32'hFFFF_FFFE, 1'b0);
        checkOutput("neg5_neg3", 33);

        applyStimulus(32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        checkOutput("intmin_by_1", 33);

        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 32'd1, 32'd0, 1'b0);
        checkOutput("intmin_by_intmin", 33);

        applyStimulus(32'd100, 32'd0, 1'b1, 32'd0, 32'd100, 1'b1);
        checkOutput("div_by_zero", 1);

        applyStimulus(32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0);
        checkOutput("after_dbz", 33);

        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b1);
        checkOutput("overflow", 1);

        for (int i = 0; i < 6; i++) begin
            a = $signed($urandom);
            if (i % 2 == 1) b = $signed($urandom_range(1, 1000));
            else b = $signed($urandom);
            if (i == 2) b = -b;
            if (b == 0) b = 5;
            if (a == 32'sh8000_0000 && b == -1) b = 3;
            qm = a / b;
            rm = a % b;
            applyStimulus(a, b, 1'b1, qm, rm, 1'b0);
            checkOutput("random", 33);
        end

        base = ready_count;
        applyStimulus(32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        compareVal("restart_no_early_ready", 32'(ready_count), 32'(base));
        applyStimulus(32'd50, 32'd7, 1'b1, 32'd7, 32'd1, 1'b0);
        checkOutput("restart", 33);
        repeat (3) @(posedge clk);
        compareVal("restart_single_ready", 32'(ready_count), 32'(base + 1));

        applyStimulus(32'd123456, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        compareVal("midreset_quotient", quotient, 32'd0);
        compareVal("midreset_remainder", remainder, 32'd0);
        compareVal("midreset_exception", {31'b0, exception}, 32'd0);
        compareVal("midreset_ready", {31'b0, ready}, 32'd0);
        compareVal("midreset_busy", {31'b0, busy}, 32'd0);
        #2;
        reset = 1'b0;
        base  = ready_count;
        repeat (40) @(posedge clk);
        #1;
        compareVal("midreset_no_ready", 32'(ready_count), 32'(base));
        compareVal("midreset_idle_busy", {31'b0, busy}, 32'd0);

        applyStimulus(32'd123456, 32'd7, 1'b1, 32'd17636, 32'd4, 1'b0);
        checkOutput("after_reset", 33);

        compareVal("sb_empty", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
